pi_vc_buffer: RTL

//  Per-VC input buffer on each pi_switch link. Sits between one switch's single-payload output
//   (payload + per-VC valid) and the next switch's VC-parallel input (per-VC payload/valid/bp).

---
 rtl/pi_vc_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/pi_vc_buffer.sv
// Per-VC input buffer between a single-payload switch output and a VC-parallel switch input.
// One FIFO per virtual channel; head flit presented per VC, advisory backpressure upstream.
module pi_vc_buffer #(
  parameter int A_W      = 4,
  parameter int D_W      = 3,
  parameter int VC_W     = 2,
  parameter int DEPTH    = 4,
  parameter int BP_SLACK = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [A_W+D_W:0]              i,
  input  logic [VC_W-1:0]               i_v,
  output logic [VC_W-1:0]               i_bp,
  output logic [VC_W*(A_W+D_W+1)-1:0]   o,
  output logic [VC_W-1:0]               o_v,
  input  logic [VC_W-1:0]               o_bp,
  output logic [VC_W-1:0]               err_overflow,
  output logic                          err_multi_v
);

  localparam int P_W   = A_W + D_W + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_BP   = CNT_W'(DEPTH - BP_SLACK);

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  logic multi_hot;
  assign multi_hot = |(i_v & (i_v - VC_W'(1)));

  logic err_multi_v_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_multi_v_reg <= 1'b0;
    end else if (multi_hot) begin
      err_multi_v_reg <= 1'b1;
    end
  end

  assign err_multi_v = err_multi_v_reg;

  genvar gi;
  generate
    for (gi = 0; gi < VC_W; gi++) begin : g_vc
      logic [P_W-1:0]   mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             err_overflow_reg;
      logic             full;
      logic             push;
      logic             pop;
      logic             overflow;

      assign full     = (count_reg == CNT_FULL);
      assign pop      = o_v[gi] && !o_bp[gi];
      // A full FIFO still accepts when its head leaves in the same cycle.
      assign push     = i_v[gi] && !multi_hot && (!full || pop);
      assign overflow = i_v[gi] && full && !pop;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_reg       <= '0;
          rd_ptr_reg       <= '0;
          count_reg        <= '0;
          err_overflow_reg <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
          if (overflow) begin
            err_overflow_reg <= 1'b1;
          end
        end
      end

      // Storage is deliberately left out of reset.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= i;
        end
      end

      assign o_v[gi]          = (count_reg != '0);
      assign i_bp[gi]         = (count_reg >= CNT_BP);
      assign o[gi*P_W +: P_W] = o_v[gi] ? mem[rd_ptr_reg] : '0;
      assign err_overflow[gi] = err_overflow_reg;
    end
  endgenerate

endmodule
